ram_arb: RTL and testbench
==========================

RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter DATA_W, default 32, data width of the shared RAM.
REQ-002 Parameter DEPTH, default 1024, requested RAM depth; implemented depth DEPTH_2N = 2**ADDR_W, where ADDR_W = $clog2(DEPTH) (derived, not overridable).
REQ-003 Parameter INIT_ZERO, default 1, 1 = zero-fill the whole RAM after reset; 0 = no fill.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 i_req_0 / i_req_1  input  1 each  request valid from requester 0 / 1.
REQ-007 i_wen_0 / i_wen_1  input  1 each  1 = write, 0 = read.
REQ-008 i_addr_0 / i_addr_1  input  ADDR_W each  word address.
REQ-009 i_wdata_0 / i_wdata_1  input  DATA_W each  write data.
REQ-010 o_gnt_0 / o_gnt_1  output  1 each  grant (ready); a transfer occurs when req and gnt are both high in the same cycle.
REQ-011 o_rvalid_0 / o_rvalid_1  output  1 each  read-data valid; one-cycle pulse per read.
REQ-012 o_rdata_0 / o_rdata_1  output  DATA_W each  read data; meaningful only while the matching rvalid is high.
REQ-013 o_init_done  output  1  RAM available to requesters.

Function
REQ-014 FSM states: INIT (zero-fill) and ARB (serve requesters); reset entry state is INIT when INIT_ZERO=1, ARB otherwise.
REQ-015 INIT: counter starts at 0; one zero write per cycle to address = counter; counter increments by 1.
REQ-016 INIT: after the write to DEPTH_2N-1, go to ARB; the fill takes exactly DEPTH_2N cycles; the counter never wraps.
REQ-017 o_init_done = 1 exactly while in ARB; o_gnt_0 and o_gnt_1 = 0 in INIT.
REQ-018 ARB: o_gnt_k is combinational from i_req_k, i_req_other, state and the round-robin pointer rr_q; at most one grant is high per cycle.
REQ-019 ARB: single requester -> granted the same cycle; both requesting -> requester rr_q granted, other gnt = 0.
REQ-020 After any transfer by requester k, rr_q <= the other requester; with no transfer, rr_q holds.
REQ-021 RAM enable = transfer or INIT write; addr, wen and wdata are muxed combinationally from the granted requester (or the fill counter in INIT).
REQ-022 Read latency: o_rvalid_k = 1 exactly one cycle after a read transfer by k; writes produce no rvalid.
REQ-023 o_rdata_0 and o_rdata_1 are both driven from the RAM output.
REQ-024 Back-to-back transfers, one per cycle, are sustained with no bubbles.
REQ-025 Same-address write then read in the next cycle returns the new data (RAM is read-first within a cycle).

Reset
REQ-026 While rstn = 0 at a clk edge, the following registers reset: o_rvalid_0 = 0, o_rvalid_1 = 0, rr_q = 0, counter = 0, state = INIT (or ARB if INIT_ZERO=0).
REQ-027 Reset mid-INIT restarts the fill from address 0.
REQ-028 Reset in the cycle after a read transfer suppresses that rvalid; in-flight reads are dropped.
REQ-029 RAM contents are not reset; they are cleared only by INIT.

Structure
REQ-030 Shared package pqr5_subsystem_pkg holds enum arb_state_t {INIT, ARB} and the requester-id type req_id_t (1 bit).
REQ-031 One sub-module: ram (single-port synchronous RAM, DATA_W/DEPTH passed through); no other storage.

Verification
REQ-032 DEPTH=16, INIT_ZERO=1, release rstn -> o_init_done rises 16 cycles later with gnt low throughout; then read addr 5 -> rdata 0x00000000.
REQ-033 Req0 writes 0xDEADBEEF to addr 3, then req1 reads addr 3 -> o_rvalid_1 pulses 1 cycle after grant with 0xDEADBEEF; o_rvalid_0 stays 0.
REQ-034 Both requesters hold continuous reads (addrs 1, 2 preloaded 0x11, 0x22) -> grants alternate 0,1,0,1; rvalid/rdata alternate 0x11, 0x22.
REQ-035 rr_q=0; req0 write 0xA5 to addr 9 and req1 read addr 9 in the same cycle -> gnt_0 first, gnt_1 next cycle, read returns 0xA5.
REQ-036 rstn low the cycle after a read grant -> no rvalid; o_init_done = 0 and the fill restarts from 0.
REQ-037 INIT_ZERO=0 -> o_init_done = 1 from the first cycle after reset release; req0 granted immediately.

Source files
------------

// File: rtl/pqr5_subsystem_pkg.sv
// Shared types for the dual-requester RAM arbiter: FSM state encoding and requester id.
package pqr5_subsystem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Round-robin hand-off: after a requester is served, priority goes to the other one.
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM, read-first: a read returns the contents from before any
// write in the same cycle. Depth is rounded up to a power of two.
module ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int DEPTH_2N = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_2N];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: no reset on the array or its output register; a reset would defeat RAM
  // inference, and the arbiter's INIT fill is what clears the contents.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (wen_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_arb.sv
// Two-requester round-robin arbiter in front of a shared single-port RAM, with an
// optional zero-fill of the whole RAM after reset.
module ram_arb
  import pqr5_subsystem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int INIT_ZERO = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int DEPTH_2N = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req_0,
  input  logic              i_wen_0,
  input  logic [ADDR_W-1:0] i_addr_0,
  input  logic [DATA_W-1:0] i_wdata_0,
  input  logic              i_req_1,
  input  logic              i_wen_1,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [DATA_W-1:0] i_wdata_1,
  output logic              o_gnt_0,
  output logic              o_gnt_1,
  output logic              o_rvalid_0,
  output logic              o_rvalid_1,
  output logic [DATA_W-1:0] o_rdata_0,
  output logic [DATA_W-1:0] o_rdata_1,
  output logic              o_init_done
);

  localparam arb_state_t        RESET_STATE = (INIT_ZERO != 0) ? INIT : ARB;
  localparam logic [ADDR_W-1:0] CNT_LAST    = ADDR_W'(DEPTH_2N - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  req_id_t           rr_q, rr_d;
  logic              rvalid_0_q, rvalid_0_d;
  logic              rvalid_1_q, rvalid_1_d;

  logic              gnt_0, gnt_1;
  logic              xfer_0, xfer_1;
  logic              ram_en, ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Grants: a lone requester wins at once; on contention rr_q picks the winner.
  // NOTE: every output of an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (state_q == ARB) begin
      gnt_0 = i_req_0 && (!i_req_1 || rr_q == REQ0);
      gnt_1 = i_req_1 && (!i_req_0 || rr_q == REQ1);
    end
  end

  assign xfer_0 = i_req_0 && gnt_0;
  assign xfer_1 = i_req_1 && gnt_1;

  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = cnt_q;
    ram_wdata = '0;
    if (state_q == INIT) begin
      ram_en  = 1'b1;
      ram_wen = 1'b1;
    end else if (xfer_0) begin
      ram_en    = 1'b1;
      ram_wen   = i_wen_0;
      ram_addr  = i_addr_0;
      ram_wdata = i_wdata_0;
    end else if (xfer_1) begin
      ram_en    = 1'b1;
      ram_wen   = i_wen_1;
      ram_addr  = i_addr_1;
      ram_wdata = i_wdata_1;
    end
  end

  // Fill counter stops on the last address rather than wrapping back to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ARB;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (xfer_0) begin
      rr_d = other_req(REQ0);
    end else if (xfer_1) begin
      rr_d = other_req(REQ1);
    end
    rvalid_0_d = xfer_0 && !i_wen_0;
    rvalid_1_d = xfer_1 && !i_wen_1;
  end

  // NOTE: non-blocking assignments for every register so all state updates see
  // the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      rr_q       <= REQ0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      rvalid_0_q <= rvalid_0_d;
      rvalid_1_q <= rvalid_1_d;
    end
  end

  ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .wen_i   (ram_wen),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign o_gnt_0     = gnt_0;
  assign o_gnt_1     = gnt_1;
  assign o_rvalid_0  = rvalid_0_q;
  assign o_rvalid_1  = rvalid_1_q;
  assign o_rdata_0   = ram_rdata;
  assign o_rdata_1   = ram_rdata;
  assign o_init_done = (state_q == ARB);

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb (DEPTH=16): directed scenarios plus random traffic, checked each
// cycle against a word-array / fairness model; a second instance covers INIT_ZERO=0.
module tb_ram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req0, wen0, req1, wen1;
  logic [3:0]  addr0, addr1;
  logic [31:0] wd0, wd1;
  logic        gnt0, gnt1, rv0, rv1, done;
  logic [31:0] rd0, rd1;

  logic        nz_req0;
  logic        nz_gnt0, nz_gnt1, nz_rv0, nz_rv1, nz_done;
  logic [31:0] nz_rd0, nz_rd1;

  ram_arb #(.DATA_W(32), .DEPTH(16), .INIT_ZERO(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .i_req_0(req0), .i_wen_0(wen0), .i_addr_0(addr0), .i_wdata_0(wd0),
    .i_req_1(req1), .i_wen_1(wen1), .i_addr_1(addr1), .i_wdata_1(wd1),
    .o_gnt_0(gnt0), .o_gnt_1(gnt1), .o_rvalid_0(rv0), .o_rvalid_1(rv1),
    .o_rdata_0(rd0), .o_rdata_1(rd1), .o_init_done(done)
  );

  ram_arb #(.DATA_W(32), .DEPTH(16), .INIT_ZERO(0)) u_dut_nz (
    .clk(clk), .rstn(rstn),
    .i_req_0(nz_req0), .i_wen_0(1'b0), .i_addr_0(4'd0), .i_wdata_0(32'd0),
    .i_req_1(1'b0), .i_wen_1(1'b0), .i_addr_1(4'd0), .i_wdata_1(32'd0),
    .o_gnt_0(nz_gnt0), .o_gnt_1(nz_gnt1), .o_rvalid_0(nz_rv0), .o_rvalid_1(nz_rv1),
    .o_rdata_0(nz_rd0), .o_rdata_1(nz_rd1), .o_init_done(nz_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: RAM contents, remaining fill cycles, last requester served,
  // and the read result due in the coming cycle.
  logic [31:0] mem_m [16];
  int          init_left;
  logic        last_served;
  logic        exp_rv0, exp_rv1;
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare just after, then advance the model.
  task automatic step(input logic rn,
                      input logic r0, input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [3:0] a1, input logic [31:0] d1);
    logic ready, g0, g1, n0, n1;
    logic [31:0] nrd;
    @(negedge clk);
    rstn = rn;
    req0 = r0; wen0 = w0; addr0 = a0; wd0 = d0;
    req1 = r1; wen1 = w1; addr1 = a1; wd1 = d1;
    #1;
    ready = (init_left == 0);
    g0 = ready && r0 && (!r1 || last_served == 1'b1);
    g1 = ready && r1 && (!r0 || last_served == 1'b0);
    check("init_done", 32'(done), 32'(ready));
    check("gnt_0", 32'(gnt0), 32'(g0));
    check("gnt_1", 32'(gnt1), 32'(g1));
    check("rvalid_0", 32'(rv0), 32'(exp_rv0));
    check("rvalid_1", 32'(rv1), 32'(exp_rv1));
    if (exp_rv0) check("rdata_0", rd0, exp_rd);
    if (exp_rv1) check("rdata_1", rd1, exp_rd);
    n0 = 1'b0; n1 = 1'b0; nrd = exp_rd;
    if (g0) begin
      if (w0) mem_m[a0] = d0; else begin n0 = 1'b1; nrd = mem_m[a0]; end
      last_served = 1'b0;
    end
    if (g1) begin
      if (w1) mem_m[a1] = d1; else begin n1 = 1'b1; nrd = mem_m[a1]; end
      last_served = 1'b1;
    end
    if (!ready && rn) begin
      mem_m[16 - init_left] = 32'd0;
      init_left--;
    end
    if (!rn) begin
      n0 = 1'b0; n1 = 1'b0;
      last_served = 1'b1;
      init_left = 16;
    end
    exp_rv0 = n0; exp_rv1 = n1; exp_rd = nrd;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    logic r0, w0, r1, w1;
    logic [3:0] a0, a1;
    rstn = 1'b0;
    req0 = 1'b0; wen0 = 1'b0; addr0 = '0; wd0 = '0;
    req1 = 1'b0; wen1 = 1'b0; addr1 = '0; wd1 = '0;
    nz_req0 = 1'b1;
    init_left = 16; last_served = 1'b1; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd = '0;
    repeat (3) @(posedge clk);

    // Fill phase: requests present but never granted; done rises after 16 cycles.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'(i), 32'd0, 1'(i), 1'b1, 4'(i), $urandom);
      if (i == 0) begin
        check("nz_init_done", 32'(nz_done), 32'd1);
        check("nz_gnt_0", 32'(nz_gnt0), 32'd1);
        nz_req0 = 1'b0;
      end
    end

    // Contention with rr at 0: write to 9 wins, read of 9 follows and sees 0xA5.
    step(1'b1, 1'b1, 1'b1, 4'd9, 32'hA5, 1'b1, 1'b0, 4'd9, 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd9, 32'd0);
    idle();

    // Freshly filled word reads as zero.
    step(1'b1, 1'b1, 1'b0, 4'd5, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    idle();

    // Write by requester 0, read by requester 1.
    step(1'b1, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd3, 32'd0);
    idle();

    // Preload, then both requesters read continuously and alternate.
    step(1'b1, 1'b1, 1'b1, 4'd1, 32'h11, 1'b0, 1'b0, 4'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd2, 32'h22);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 4'd1, 32'd0, 1'b1, 1'b0, 4'd2, 32'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = 4'($urandom_range(0, 15)); a1 = 4'($urandom_range(0, 15));
      step(1'b1, r0, w0, a0, $urandom, r1, w1, a1, $urandom);
    end
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'b1, 4'(i), 32'hC0DE_0000 | 32'(i), 1'b0, 1'b0, 4'd0, 32'd0);

    // Reset at the edge closing a read transfer: rvalid dropped, fill restarts.
    step(1'b0, 1'b1, 1'b0, 4'd4, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 6; i++) idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 16; i++) idle();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'b0, 4'(i), 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
